ct_compress_pack: RTL and testbench

Encryption-side ciphertext compressor/packer, directly downstream of the reduce stage. It reads reduced 12-bit coefficients of u = (Bp0, Bp1) and v from the EncBp and EncV BRAMs, which hold 96-bit words of 8 coefficients each. It applies Kyber Compress_du / Compress_dv and packs the resulting bitstream little-endian into a 32-bit ciphertext BRAM (192 words = 768 bytes for Kyber512).

---
 rtl/ct_compress_pack.sv | 201 ++++++++++++++++++++
 tb/tb_ct_compress_pack.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ct_compress_pack.sv
// Ciphertext compressor/packer: Compress_du on u (Bp0, Bp1) and Compress_dv on v,
// packed little-endian into 32-bit ciphertext words on a fixed cycle schedule.
module ct_compress_pack #(
    parameter int KYBER_K       = 2,
    parameter int KYBER_Q       = 3329,
    parameter int DU            = 10,
    parameter int DV            = 4,
    parameter int i_BRAM_Length = 96,
    parameter int o_Word_Width  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    output logic [5:0]               EncBp_RAd,
    input  logic [i_BRAM_Length-1:0] EncBp_RData,
    output logic [4:0]               EncV_RAd,
    input  logic [i_BRAM_Length-1:0] EncV_RData,
    output logic                     Ct_outready,
    output logic [7:0]               Ct_WAd,
    output logic [o_Word_Width-1:0]  Ct_WData,
    output logic                     Function_done
);

    localparam int COEFFS  = i_BRAM_Length / 12;
    localparam int CHUNK_W = COEFFS * DU;
    localparam int BUF_W   = 128;
    localparam int SHIFT   = 34;

    localparam logic [47:0] RECIP    = 48'(((64'd1 << SHIFT) + 64'(KYBER_Q) - 64'd1) / 64'(KYBER_Q));
    localparam logic [47:0] HALF_Q   = 48'((KYBER_Q - 1) / 2);
    localparam logic [6:0]  BP_FILL  = 7'(CHUNK_W);
    localparam logic [6:0]  V_FILL   = 7'(COEFFS * DV);
    localparam logic [6:0]  WORD     = 7'(o_Word_Width);
    localparam logic [6:0]  TWO_WORD = 7'(2 * o_Word_Width);
    localparam logic [5:0]  BP_LAST  = 6'(KYBER_K * 32 - 1);
    localparam logic [4:0]  V_LAST   = 5'd31;

    typedef enum logic [3:0] {
        IDLE, RD_BP, CMP_BP, APP_BP, EMIT_BP, RD_V, CMP_V, APP_V, EMIT_V, DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [5:0]                bp_rad_q, bp_rad_d;
    logic [4:0]                v_rad_q, v_rad_d;
    logic [CHUNK_W-1:0]        chunk_q, chunk_d;
    logic [BUF_W-1:0]          buf_q, buf_d;
    logic [6:0]                fill_q, fill_d;
    logic [7:0]                wr_ptr_q, wr_ptr_d;
    logic [7:0]                wad_q, wad_d;
    logic [o_Word_Width-1:0]   wdata_q, wdata_d;
    logic                      ordy_q, ordy_d;
    logic                      done_q, done_d;
    logic [1:0]                tail_q, tail_d;

    // floor((x*2^d + (q-1)/2) / q) via a ceiling reciprocal; exact for every 12-bit x.
    function automatic logic [DU-1:0] comp_u(input logic [11:0] x);
        logic [47:0] p;
        p = ({36'd0, x} << DU) + HALF_Q;
        p = p * RECIP;
        return DU'(p >> SHIFT);
    endfunction

    function automatic logic [DV-1:0] comp_v(input logic [11:0] x);
        logic [47:0] p;
        p = ({36'd0, x} << DV) + HALF_Q;
        p = p * RECIP;
        return DV'(p >> SHIFT);
    endfunction

    always_comb begin
        state_d  = state_q;
        bp_rad_d = bp_rad_q;
        v_rad_d  = v_rad_q;
        chunk_d  = chunk_q;
        buf_d    = buf_q;
        fill_d   = fill_q;
        wr_ptr_d = wr_ptr_q;
        wad_d    = wad_q;
        wdata_d  = wdata_q;
        ordy_d   = 1'b0;
        done_d   = 1'b0;
        tail_d   = tail_q;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d  = RD_BP;
                    bp_rad_d = '0;
                    wr_ptr_d = '0;
                    buf_d    = '0;
                    fill_d   = '0;
                end
            end
            RD_BP:  state_d = CMP_BP;
            CMP_BP: begin
                for (int unsigned j = 0; j < COEFFS; j++)
                    chunk_d[j*DU +: DU] = comp_u(EncBp_RData[j*12 +: 12]);
                state_d = APP_BP;
            end
            APP_BP: begin
                buf_d   = buf_q | (BUF_W'(chunk_q) << fill_q);
                fill_d  = fill_q + BP_FILL;
                state_d = EMIT_BP;
            end
            EMIT_BP: begin
                ordy_d   = 1'b1;
                wad_d    = wr_ptr_q;
                wdata_d  = buf_q[o_Word_Width-1:0];
                wr_ptr_d = wr_ptr_q + 8'd1;
                buf_d    = buf_q >> o_Word_Width;
                fill_d   = fill_q - WORD;
                // Leave on the last emitted word so no cycle is spent on fill < 32.
                if (fill_q < TWO_WORD) begin
                    if (bp_rad_q == BP_LAST) begin
                        state_d = RD_V;
                        v_rad_d = '0;
                    end else begin
                        state_d  = RD_BP;
                        bp_rad_d = bp_rad_q + 6'd1;
                    end
                end
            end
            RD_V:  state_d = CMP_V;
            CMP_V: begin
                chunk_d = '0;
                for (int unsigned j = 0; j < COEFFS; j++)
                    chunk_d[j*DV +: DV] = comp_v(EncV_RData[j*12 +: 12]);
                state_d = APP_V;
            end
            APP_V: begin
                buf_d   = buf_q | (BUF_W'(chunk_q) << fill_q);
                fill_d  = fill_q + V_FILL;
                state_d = EMIT_V;
            end
            EMIT_V: begin
                ordy_d   = 1'b1;
                wad_d    = wr_ptr_q;
                wdata_d  = buf_q[o_Word_Width-1:0];
                wr_ptr_d = wr_ptr_q + 8'd1;
                buf_d    = buf_q >> o_Word_Width;
                fill_d   = fill_q - WORD;
                if (fill_q < TWO_WORD) begin
                    if (v_rad_q == V_LAST) begin
                        state_d = DONE;
                        tail_d  = '0;
                    end else begin
                        state_d = RD_V;
                        v_rad_d = v_rad_q + 5'd1;
                    end
                end
            end
            DONE: begin
                // Three-cycle tail: done lands 482 cycles after start, runs repeat every 484.
                tail_d = tail_q + 2'd1;
                if (tail_q == 2'd0)
                    done_d = 1'b1;
                if (tail_q == 2'd2)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            bp_rad_q <= '0;
            v_rad_q  <= '0;
            chunk_q  <= '0;
            buf_q    <= '0;
            fill_q   <= '0;
            wr_ptr_q <= '0;
            wad_q    <= '0;
            wdata_q  <= '0;
            ordy_q   <= 1'b0;
            done_q   <= 1'b0;
            tail_q   <= '0;
        end else begin
            state_q  <= state_d;
            bp_rad_q <= bp_rad_d;
            v_rad_q  <= v_rad_d;
            chunk_q  <= chunk_d;
            buf_q    <= buf_d;
            fill_q   <= fill_d;
            wr_ptr_q <= wr_ptr_d;
            wad_q    <= wad_d;
            wdata_q  <= wdata_d;
            ordy_q   <= ordy_d;
            done_q   <= done_d;
            tail_q   <= tail_d;
        end
    end

    assign EncBp_RAd     = bp_rad_q;
    assign EncV_RAd      = v_rad_q;
    assign Ct_outready   = ordy_q;
    assign Ct_WAd        = wad_q;
    assign Ct_WData      = wdata_q;
    assign Function_done = done_q;

endmodule

// File: tb/tb_ct_compress_pack.sv
// Bench for ct_compress_pack: BRAM models, integer-division reference packer feeding a
// write scoreboard, a constant-pattern table, and hand sequences for enable/rst corners.
module tb_ct_compress_pack;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [5:0]  bp_rad;
    logic [95:0] bp_rdata;
    logic [4:0]  v_rad;
    logic [95:0] v_rdata;
    logic        ct_rdy;
    logic [7:0]  ct_wad;
    logic [31:0] ct_wdata;
    logic        done;

    always #5 clk = ~clk;

    ct_compress_pack #(
        .KYBER_K(2), .KYBER_Q(3329), .DU(10), .DV(4), .i_BRAM_Length(96), .o_Word_Width(32)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .EncBp_RAd(bp_rad), .EncBp_RData(bp_rdata),
        .EncV_RAd(v_rad), .EncV_RData(v_rdata),
        .Ct_outready(ct_rdy), .Ct_WAd(ct_wad), .Ct_WData(ct_wdata),
        .Function_done(done)
    );

    logic [95:0] bp_mem [64];
    logic [95:0] v_mem  [32];
    logic [31:0] ct_img [256];
    logic [39:0] exp_q  [$];

    int n_vec    = 0;
    int n_fail   = 0;
    int n_strobe = 0;

    always @(posedge clk) begin
        bp_rdata <= bp_mem[bp_rad];
        v_rdata  <= v_mem[v_rad];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic int ref_comp(input int x, input int d);
        return ((x * (1 << d) + 1664) / 3329) % (1 << d);
    endfunction

    task automatic push_expected();
        logic [6143:0] s;
        int pos;
        int c;
        s   = '0;
        pos = 0;
        for (int w = 0; w < 64; w++)
            for (int j = 0; j < 8; j++) begin
                c = ref_comp(int'(bp_mem[w][12*j +: 12]), 10);
                s[pos +: 10] = 10'(c);
                pos += 10;
            end
        for (int w = 0; w < 32; w++)
            for (int j = 0; j < 8; j++) begin
                c = ref_comp(int'(v_mem[w][12*j +: 12]), 4);
                s[pos +: 4] = 4'(c);
                pos += 4;
            end
        for (int n = 0; n < 192; n++)
            exp_q.push_back({8'(n), s[32*n +: 32]});
    endtask

    task automatic load(input int mode, input logic [11:0] bv, input logic [11:0] vv);
        logic [95:0] t;
        for (int w = 0; w < 64; w++)
            for (int j = 0; j < 8; j++)
                bp_mem[w][12*j +: 12] = (mode == 0) ? bv : 12'($urandom_range(3328));
        for (int w = 0; w < 32; w++)
            for (int j = 0; j < 8; j++)
                v_mem[w][12*j +: 12] = (mode == 0) ? vv : 12'($urandom_range(3328));
        if (mode == 1) begin
            t = {12'd0, 12'd1, 12'd2, 12'd3328, 12'd3328, 12'd2, 12'd1, 12'd0};
            bp_mem[0] = t;
        end
    endtask

    // Scoreboard side: every strobe must match the next expected {address, word}.
    always @(negedge clk) begin
        if (ct_rdy) begin
            logic [39:0] e;
            n_strobe++;
            ct_img[ct_wad] = ct_wdata;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_strobe: got addr %0d data 0x%08h, want no strobe", ct_wad, ct_wdata);
            end else begin
                e = exp_q.pop_front();
                check("ct_addr_word", {24'd0, ct_wad, ct_wdata}, {24'd0, e});
            end
        end
    end

    task automatic run_one(input int pa, input int pb);
        int k;
        int base;
        base = n_strobe;
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        k = 1;
        while (!done && k < 1500) begin
            enable = (k == pa || k == pb);
            @(negedge clk);
            k++;
        end
        enable = 1'b0;
        check("done_latency", 64'(k), 64'd482);
        check("fill_at_done", 64'(dut.fill_q), 64'd0);
        @(negedge clk);
        check("done_one_cycle", 64'(done), 64'd0);
        repeat (4) @(negedge clk);
        check("strobe_count", 64'(n_strobe - base), 64'd192);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    endtask

    typedef struct {
        int          mode;
        logic [11:0] bp_val;
        logic [11:0] v_val;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w160;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int t1;
        int t2;
        int k;
        int base;

        vecs[0] = '{0, 12'd1664, 12'd1664, 32'h20080200, 32'h08020080, 32'h88888888};
        vecs[1] = '{0, 12'd0,    12'd0,    32'h00000000, 32'h00000000, 32'h00000000};
        vecs[2] = '{0, 12'd3328, 12'd3328, 32'h00000000, 32'h00000000, 32'h00000000};
        vecs[3] = '{0, 12'd2,    12'd105,  32'h40100401, 32'h10040100, 32'h11111111};
        vecs[4] = '{0, 12'd4095, 12'd104,  32'h0EC3B0EC, 32'hC3B0EC3B, 32'h00000000};
        vecs[5] = '{1, 12'd0,    12'd0,    32'h00100000, 32'h00040000, 32'h00000000};
        vecs[6] = '{2, 12'd0,    12'd0,    32'h00000000, 32'h00000000, 32'h00000000};

        rst    = 1'b1;
        enable = 1'b0;
        load(0, 12'd0, 12'd0);
        repeat (3) @(negedge clk);
        check("rst_outready", 64'(ct_rdy), 64'd0);
        check("rst_wad", 64'(ct_wad), 64'd0);
        check("rst_wdata", 64'(ct_wdata), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_bp_rad", 64'(bp_rad), 64'd0);
        check("rst_v_rad", 64'(v_rad), 64'd0);
        check("rst_fill", 64'(dut.fill_q), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            load(vecs[i].mode, vecs[i].bp_val, vecs[i].v_val);
            exp_q.delete();
            push_expected();
            run_one(0, 0);
            if (vecs[i].mode != 2) begin
                check("table_w0", 64'(ct_img[0]), 64'(vecs[i].w0));
                check("table_w1", 64'(ct_img[1]), 64'(vecs[i].w1));
            end
            if (vecs[i].mode == 0)
                check("table_w160", 64'(ct_img[160]), 64'(vecs[i].w160));
        end

        // enable pulses mid-run are ignored
        load(2, 12'd0, 12'd0);
        exp_q.delete();
        push_expected();
        run_one(100, 300);

        // rst at cycle 200 abandons the run
        load(2, 12'd0, 12'd0);
        exp_q.delete();
        push_expected();
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        repeat (199) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_outready", 64'(ct_rdy), 64'd0);
        check("abort_wad", 64'(ct_wad), 64'd0);
        check("abort_wdata", 64'(ct_wdata), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_bp_rad", 64'(bp_rad), 64'd0);
        check("abort_v_rad", 64'(v_rad), 64'd0);
        check("abort_fill", 64'(dut.fill_q), 64'd0);
        exp_q.delete();
        base = n_strobe;
        repeat (30) @(negedge clk);
        check("abort_no_strobes", 64'(n_strobe - base), 64'd0);
        push_expected();
        run_one(0, 0);

        // enable held high: two back-to-back runs
        load(2, 12'd0, 12'd0);
        exp_q.delete();
        push_expected();
        push_expected();
        base = n_strobe;
        t1 = 0;
        t2 = 0;
        k  = 0;
        @(negedge clk);
        enable = 1'b1;
        while (t2 == 0 && k < 1500) begin
            @(negedge clk);
            k++;
            if (done) begin
                if (t1 == 0) begin
                    t1 = k;
                end else begin
                    t2 = k;
                    enable = 1'b0;
                end
            end
        end
        enable = 1'b0;
        repeat (8) @(negedge clk);
        check("held_first_done", 64'(t1), 64'd482);
        check("held_period", 64'(t2 - t1), 64'd484);
        check("held_strobes", 64'(n_strobe - base), 64'd384);
        check("held_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
